fp_acc: RTL and testbench
=========================

FP_ACC -- requirements
Module: fp_acc

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the accepted-operand counter.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream product on in_data is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-006 SHALL have port in_data  input  32  IEEE-754 single product, output of the float multiplier.
REQ-007 SHALL have port in_last  input  1  operand is the final one of the current group.
REQ-008 SHALL have port out_valid  output  1  group sum available.
REQ-009 SHALL have port out_ready  input  1  downstream takes the sum.
REQ-010 SHALL have port out_data  output  32  accumulated sum, single-precision.
REQ-011 SHALL have port out_count  output  CNT_W  operands accepted in the group.
REQ-012 SHALL have port overflow  output  1  sticky: group sum saturated to +infinity.

Function
REQ-013 SHALL accept an operand only on a cycle where in_valid and in_ready are both 1; in_ready SHALL be 1 only in state IDLE.
REQ-014 SHALL implement states IDLE, ALIGN, ADD, NORM, DONE; accept: IDLE->ALIGN, latching in_data and in_last, incrementing count (saturating at all-ones).
REQ-015 SHALL ignore in_data[31]; all operands treated positive; out_data[31] SHALL always be 0.
REQ-016 SHALL treat exponent 0 as zero (fraction ignored, no denormals), exponent 255 as +infinity (fraction ignored).
REQ-017 SHALL form 24-bit mantissas {1,frac} for nonzero finite values; acc and operand compared by exponent.
REQ-018 ALIGN: per cycle, smaller-exponent mantissa shifted right 1 and its exponent incremented while exponents differ; exponent difference >=25 SHALL zero the smaller mantissa in a single cycle; ALIGN SHALL exit in the cycle exponents are equal, either operand is zero, or either is infinity (minimum 1 cycle).
REQ-019 ADD: 25-bit unsigned sum of aligned mantissas; a zero operand passes the other unchanged.
REQ-020 NORM: if sum bit 24 set, shift right 1 (truncate, no rounding) and exponent+1; result written to acc.
REQ-021 NORM: result exponent reaching 255, or either operand infinity, SHALL give acc = 0x7F800000 and set overflow; infinity SHALL persist for rest of group.
REQ-022 NORM SHALL go to DONE if latched in_last=1, else IDLE.
REQ-023 DONE: out_valid=1; out_data, out_count, overflow SHALL hold stable while out_ready=0.
REQ-024 DONE with out_ready=1: acc cleared to 0, count cleared to 0, overflow cleared, next state IDLE.
REQ-025 Latency, equal exponents: operand accepted at edge k -> out_valid=1 after edge k+3 (ALIGN, ADD, NORM one cycle each); each extra shift adds one cycle.
REQ-026 out_data SHALL equal acc at all times; out_count SHALL equal count.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, acc=0, count=0, overflow=0, out_valid=0, in_ready=1 (once rst released), regardless of current state.
REQ-028 Reset mid-ALIGN/ADD/NORM SHALL discard the in-flight operand; no partial result SHALL appear after release.

Verification
REQ-029 Reset: assert rst mid-ALIGN -> out_valid=0, out_data=0, out_count=0, overflow=0, in_ready=1 after release.
REQ-030 Single 0x3F800000 with in_last -> out_data 0x3F800000, out_count 1, out_valid 3 edges after acceptance edge.
REQ-031 0x3FC00000 then 0x3F400000 (last) -> out_data 0x40100000, out_count 2, second operand ALIGN 2 cycles.
REQ-032 0x3F800000 then 0x30800000 (last, diff 30) -> out_data 0x3F800000, ALIGN 1 cycle.
REQ-033 0x7F000000 then 0x7F000000 (last) -> out_data 0x7F800000, overflow=1; next group starts with overflow=0.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> out_data/out_count stable, in_ready=0; out_ready=1 -> IDLE, acc 0.

Source files
------------

// File: rtl/fp_acc.sv
// rtl/fp_acc.sv - positive-only single-precision accumulator with
// serial alignment, truncating normalisation and sticky +inf saturation.
module fp_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  state_t state, state_nx;

  logic [31:0]      acc;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             last_q;

  // working copies: a_* is the accumulator side, o_* the incoming operand
  logic [7:0]  a_e, o_e;
  logic [23:0] a_m, o_m;
  logic        a_zero, o_zero, a_inf, o_inf;
  logic [24:0] sum;
  logic [7:0]  res_e;

  logic        a_gt;
  logic [7:0]  diff;
  logic        align_done;
  logic        far;
  logic [8:0]  norm_e;
  logic [23:0] norm_m;
  logic        norm_inf;

  always_comb begin
    a_gt       = a_e > o_e;
    diff       = a_gt ? (a_e - o_e) : (o_e - a_e);
    align_done = a_zero | o_zero | a_inf | o_inf | (a_e == o_e);
    far        = diff >= 8'd25;
  end

  always_comb begin
    if (sum[24]) begin
      norm_e = {1'b0, res_e} + 9'd1;
      norm_m = sum[24:1];
    end else begin
      norm_e = {1'b0, res_e};
      norm_m = sum[23:0];
    end
    norm_inf = norm_e >= 9'd255;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = ALIGN;
      ALIGN:   if (align_done || far) state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = last_q ? DONE : IDLE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      last_q <= 1'b0;
      a_e    <= '0;
      o_e    <= '0;
      a_m    <= '0;
      o_m    <= '0;
      a_zero <= 1'b1;
      o_zero <= 1'b1;
      a_inf  <= 1'b0;
      o_inf  <= 1'b0;
      sum    <= '0;
      res_e  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            last_q <= in_last;
            if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            o_e    <= in_data[30:23];
            o_zero <= in_data[30:23] == 8'd0;
            o_inf  <= in_data[30:23] == 8'hFF;
            o_m    <= (in_data[30:23] == 8'd0) ? 24'd0 : {1'b1, in_data[22:0]};
            a_e    <= acc[30:23];
            a_zero <= acc[30:23] == 8'd0;
            a_inf  <= acc[30:23] == 8'hFF;
            a_m    <= (acc[30:23] == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
          end
        end
        ALIGN: begin
          if (!align_done) begin
            // a far-away smaller operand contributes nothing after truncation
            if (far) begin
              if (a_gt) begin
                o_m <= '0;
                o_e <= a_e;
              end else begin
                a_m <= '0;
                a_e <= o_e;
              end
            end else if (a_gt) begin
              o_m <= o_m >> 1;
              o_e <= o_e + 8'd1;
            end else begin
              a_m <= a_m >> 1;
              a_e <= a_e + 8'd1;
            end
          end
        end
        ADD: begin
          if (a_zero)      sum <= {1'b0, o_m};
          else if (o_zero) sum <= {1'b0, a_m};
          else             sum <= {1'b0, a_m} + {1'b0, o_m};
          res_e <= a_zero ? o_e : a_e;
        end
        NORM: begin
          if (a_inf || o_inf || norm_inf) begin
            acc <= POS_INF;
            ovf <= 1'b1;
          end else if (sum == 25'd0) begin
            acc <= '0;
          end else begin
            acc <= {1'b0, norm_e[7:0], norm_m[22:0]};
          end
        end
        DONE: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign out_count = count;
  assign overflow  = ovf;

endmodule

// File: tb/tb_fp_acc.sv
// tb/tb_fp_acc.sv - self-checking bench for fp_acc: directed cases plus
// randomized groups against a value-level reference model.
module tb_fp_acc;

  localparam int CNT_W = 16;
  localparam logic [31:0] INF = 32'h7F80_0000;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;

  fp_acc #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value-level sum of two positive floats with truncation.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, d, e;
    longint ma, mb, s, t;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return INF;
    if (eb == 0) return a;
    if (ea == 0) return {1'b0, b[30:0]};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    if (ea < eb) begin
      e = ea; ea = eb; eb = e;
      t = ma; ma = mb; mb = t;
    end
    d = ea - eb;
    mb = (d >= 25) ? 0 : (mb >> d);
    s = ma + mb;
    e = ea;
    if (s >= (longint'(1) << 24)) begin
      s = s >> 1;
      e = e + 1;
    end
    if (e >= 255) return INF;
    return {1'b0, 8'(e), 23'(s)};
  endfunction

  function automatic int align_cycles(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, d;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0 || ea == 255 || eb == 255) return 1;
    d = (ea > eb) ? ea - eb : eb - ea;
    if (d == 0 || d >= 25) return 1;
    return 1 + d;
  endfunction

  // Offer one operand; lat = edges from acceptance until out_valid (last) or in_ready.
  task automatic send(input logic [31:0] d, input logic l, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(l ? out_valid : in_ready) && lat < 200);
  endtask

  task automatic release_group();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== '0 ||
        overflow !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b data=%h count=%0d ovf=%b ready=%b, required 0/0/0/0/1",
               out_valid, out_data, out_count, overflow, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    in_last  = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== '0 ||
        overflow !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_align: valid=%b data=%h count=%0d ovf=%b ready=%b, required 0/0/0/0/1",
               out_valid, out_data, out_count, overflow, in_ready);
    end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_no_partial: valid=%b data=%h, required 0/00000000", out_valid, out_data);
    end
  endtask

  task automatic test_single();
    int lat;
    send(32'h3F80_0000, 1'b1, lat);
    n_cmp++;
    if (lat !== 3 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_latency: got %0d valid=%b, required 3 valid=1", lat, out_valid);
    end
    n_cmp++;
    if (out_data !== 32'h3F80_0000 || out_count !== 16'd1) begin
      n_bad++;
      $display("FAIL single_value: data=%h count=%0d, required 3f800000 count 1", out_data, out_count);
    end
    release_group();
  endtask

  task automatic test_align_two();
    int lat;
    send(32'h3FC0_0000, 1'b0, lat);
    send(32'h3F40_0000, 1'b1, lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL align2_latency: got %0d, required 4", lat);
    end
    n_cmp++;
    if (out_data !== 32'h4010_0000 || out_count !== 16'd2) begin
      n_bad++;
      $display("FAIL align2_value: data=%h count=%0d, required 40100000 count 2", out_data, out_count);
    end
    release_group();
  endtask

  task automatic test_far();
    int lat;
    send(32'h3F80_0000, 1'b0, lat);
    send(32'hB080_0000, 1'b1, lat);
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL far_latency: got %0d, required 3", lat);
    end
    n_cmp++;
    if (out_data !== 32'h3F80_0000 || out_count !== 16'd2) begin
      n_bad++;
      $display("FAIL far_value: data=%h count=%0d, required 3f800000 count 2", out_data, out_count);
    end
    release_group();
  endtask

  task automatic test_overflow();
    int lat;
    send(32'h7F00_0000, 1'b0, lat);
    send(32'h7F00_0000, 1'b1, lat);
    n_cmp++;
    if (out_data !== INF || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_value: data=%h ovf=%b, required 7f800000 ovf 1", out_data, overflow);
    end
    release_group();
    send(32'h4000_0000, 1'b1, lat);
    n_cmp++;
    if (out_data !== 32'h4000_0000 || overflow !== 1'b0 || out_count !== 16'd1) begin
      n_bad++;
      $display("FAIL ovf_next_group: data=%h ovf=%b count=%0d, required 40000000 ovf 0 count 1",
               out_data, overflow, out_count);
    end
    release_group();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] exp_d;
    exp_d = ref_add(32'h4040_0000, 32'h3F80_0000);
    send(32'h4040_0000, 1'b0, lat);
    send(32'h3F80_0000, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d || out_count !== 16'd2) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b data=%h count=%0d, required 1/0/%h/2",
                 i, out_valid, in_ready, out_data, out_count, exp_d);
      end
    end
    release_group();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== '0) begin
      n_bad++;
      $display("FAIL bp_release: ready=%b valid=%b data=%h count=%0d, required 1/0/0/0",
               in_ready, out_valid, out_data, out_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] macc, d;
    logic        movf;
    int          ngrp, lat, want, sel;
    logic [7:0]  e;
    for (int g = 0; g < 25; g++) begin
      macc = 32'd0;
      movf = 1'b0;
      ngrp = $urandom_range(1, 4);
      for (int k = 0; k < ngrp; k++) begin
        sel = $urandom_range(0, 19);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'd255;
        else if (sel == 2) e = 8'($urandom_range(248, 254));
        else               e = 8'($urandom_range(115, 140));
        d = {1'($urandom), e, 23'($urandom)};
        want = align_cycles(macc, d) + 2;
        send(d, k == ngrp - 1, lat);
        macc = ref_add(macc, d);
        if (macc == INF) movf = 1'b1;
        n_cmp++;
        if (lat !== want) begin
          n_bad++;
          $display("FAIL rand_latency g%0d op%0d (%h): got %0d, required %0d", g, k, d, lat, want);
        end
      end
      n_cmp++;
      if (out_data !== macc || out_count !== 16'(ngrp) || overflow !== movf) begin
        n_bad++;
        $display("FAIL rand_group g%0d: data=%h count=%0d ovf=%b, required %h/%0d/%b",
                 g, out_data, out_count, overflow, macc, ngrp, movf);
      end
      release_group();
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_single();
    test_align_two();
    test_far();
    test_overflow();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
